// File: rtl/keccak_pkg.sv
// rtl/keccak_pkg.sv - shared types and constants for the Keccak-f[1600] round sequencer
package keccak_pkg;

    localparam int NROUNDS = 24;
    localparam int NSLICES = 64;
    localparam int NLANES  = 25;
    localparam int TIMEOUT = 255;

    localparam int SLICE_W = 6;
    localparam int LANE_W  = 5;
    localparam int ROUND_W = 5;
    localparam int WDOG_W  = 8;

    typedef enum logic [3:0] {
        IDLE,
        TH_INIT,
        TH_RUN,
        RHO_INIT,
        RHO_RUN,
        PI_INIT,
        PI_RUN,
        CHI_INIT,
        CHI_RUN,
        IOTA_INIT,
        IOTA_RUN,
        FINISH,
        ERR
    } ctrl_state_t;

    function automatic logic isRunState(input ctrl_state_t s);
        return s inside {TH_RUN, RHO_RUN, PI_RUN, CHI_RUN, IOTA_RUN};
    endfunction

endpackage

// File: rtl/keccak_round_ctrl_if.sv
// rtl/keccak_round_ctrl_if.sv - sequencer <-> step datapath control bundle
interface keccak_round_ctrl_if;
    import keccak_pkg::*;

    logic               start;
    logic               colparDone;
    logic               finishLane;
    logic               permDone;
    logic               revalDone;
    logic               addRCDone;
    logic               colparIJrster;
    logic               initRotate;
    logic               IJen;
    logic               initLine;
    logic               initReval;
    logic               initARC;
    logic [SLICE_W-1:0] sliceIdx;
    logic [LANE_W-1:0]  laneIdx;
    logic [ROUND_W-1:0] roundIdx;
    logic               busy;
    logic               perm_done;
    logic               err;

    modport master (
        input  start, colparDone, finishLane, permDone, revalDone, addRCDone,
        output colparIJrster, initRotate, IJen, initLine, initReval, initARC,
        output sliceIdx, laneIdx, roundIdx, busy, perm_done, err
    );

    modport slave (
        output start, colparDone, finishLane, permDone, revalDone, addRCDone,
        input  colparIJrster, initRotate, IJen, initLine, initReval, initARC,
        input  sliceIdx, laneIdx, roundIdx, busy, perm_done, err
    );

endinterface

// File: rtl/keccak_wdog.sv
// rtl/keccak_wdog.sv - saturating run-cycle watchdog with timeout compare
module keccak_wdog #(
    parameter int W       = 8,
    parameter int TIMEOUT = 255
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic en,
    output logic expired
);

    localparam logic [W-1:0] LAST = W'(TIMEOUT - 1);

    logic [W-1:0] count;

    always_ff @(posedge clk) begin
        if (rst || clr) begin
            count <= '0;
        end else if (en && (count != '1)) begin
            count <= count + 1'b1;
        end
    end

    // Fires in the RUN cycle that takes the count to TIMEOUT.
    assign expired = en && (count >= LAST);

endmodule

// File: rtl/keccak_round_ctrl.sv
// rtl/keccak_round_ctrl.sv - Keccak-f[1600] step/round sequencer with watchdog
module keccak_round_ctrl #(
    parameter int NROUNDS = keccak_pkg::NROUNDS,
    parameter int NSLICES = keccak_pkg::NSLICES,
    parameter int NLANES  = keccak_pkg::NLANES,
    parameter int TIMEOUT = keccak_pkg::TIMEOUT
) (
    input logic                 clk,
    input logic                 rst,
    keccak_round_ctrl_if.master bus
);
    import keccak_pkg::*;

    ctrl_state_t        state, nextState;
    logic [SLICE_W-1:0] sliceQ, sliceD;
    logic [LANE_W-1:0]  laneQ, laneD;
    logic [ROUND_W-1:0] roundQ, roundD;
    logic               thStb, rhoStb, piStb, chiStb, iotaStb;
    logic               busyQ, permDoneQ, errQ;
    logic               runEn, expired;
    logic               lastSlice, lastLane, lastRound;

    assign runEn     = isRunState(state);
    assign lastSlice = (sliceQ == SLICE_W'(NSLICES - 1));
    assign lastLane  = (laneQ == LANE_W'(NLANES - 1));
    assign lastRound = (roundQ == ROUND_W'(NROUNDS - 1));

    keccak_wdog #(
        .W       (WDOG_W),
        .TIMEOUT (TIMEOUT)
    ) wdog (
        .clk     (clk),
        .rst     (rst),
        .clr     (!runEn),
        .en      (runEn),
        .expired (expired)
    );

    always_comb begin
        nextState = state;
        sliceD    = sliceQ;
        laneD     = laneQ;
        roundD    = roundQ;
        case (state)
            IDLE: begin
                if (bus.start) begin
                    nextState = TH_INIT;
                    sliceD    = '0;
                    laneD     = '0;
                    roundD    = '0;
                end
            end
            TH_INIT:   nextState = TH_RUN;
            RHO_INIT:  nextState = RHO_RUN;
            PI_INIT:   nextState = PI_RUN;
            CHI_INIT:  nextState = CHI_RUN;
            IOTA_INIT: nextState = IOTA_RUN;
            // A done flag outranks a watchdog expiry landing in the same cycle.
            TH_RUN: begin
                if (bus.colparDone) begin
                    sliceD    = lastSlice ? '0 : sliceQ + 1'b1;
                    nextState = lastSlice ? RHO_INIT : TH_INIT;
                end else if (expired) begin
                    nextState = ERR;
                end
            end
            RHO_RUN: begin
                if (bus.finishLane) begin
                    laneD     = lastLane ? '0 : laneQ + 1'b1;
                    nextState = lastLane ? PI_INIT : RHO_INIT;
                end else if (expired) begin
                    nextState = ERR;
                end
            end
            PI_RUN: begin
                if (bus.permDone) begin
                    sliceD    = lastSlice ? '0 : sliceQ + 1'b1;
                    nextState = lastSlice ? CHI_INIT : PI_INIT;
                end else if (expired) begin
                    nextState = ERR;
                end
            end
            CHI_RUN: begin
                if (bus.revalDone) begin
                    sliceD    = lastSlice ? '0 : sliceQ + 1'b1;
                    nextState = lastSlice ? IOTA_INIT : CHI_INIT;
                end else if (expired) begin
                    nextState = ERR;
                end
            end
            IOTA_RUN: begin
                if (bus.addRCDone) begin
                    roundD    = lastRound ? roundQ : roundQ + 1'b1;
                    nextState = lastRound ? FINISH : TH_INIT;
                end else if (expired) begin
                    nextState = ERR;
                end
            end
            FINISH:  nextState = IDLE;
            ERR:     nextState = ERR;
            default: nextState = ERR;
        endcase
    end

    // Outputs are registered from the next state so they line up with it.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            sliceQ    <= '0;
            laneQ     <= '0;
            roundQ    <= '0;
            thStb     <= 1'b0;
            rhoStb    <= 1'b0;
            piStb     <= 1'b0;
            chiStb    <= 1'b0;
            iotaStb   <= 1'b0;
            busyQ     <= 1'b0;
            permDoneQ <= 1'b0;
            errQ      <= 1'b0;
        end else begin
            state     <= nextState;
            sliceQ    <= sliceD;
            laneQ     <= laneD;
            roundQ    <= roundD;
            thStb     <= (nextState == TH_INIT);
            rhoStb    <= (nextState == RHO_INIT);
            piStb     <= (nextState == PI_INIT);
            chiStb    <= (nextState == CHI_INIT);
            iotaStb   <= (nextState == IOTA_INIT);
            busyQ     <= (nextState != IDLE) && (nextState != ERR);
            permDoneQ <= (nextState == FINISH);
            errQ      <= errQ || (nextState == ERR);
        end
    end

    assign bus.colparIJrster = thStb;
    assign bus.initRotate    = rhoStb;
    assign bus.IJen          = piStb;
    assign bus.initLine      = piStb;
    assign bus.initReval     = chiStb;
    assign bus.initARC       = iotaStb;
    assign bus.sliceIdx      = sliceQ;
    assign bus.laneIdx       = laneQ;
    assign bus.roundIdx      = roundQ;
    assign bus.busy          = busyQ;
    assign bus.perm_done     = permDoneQ;
    assign bus.err           = errQ;

endmodule

// File: tb/tb_keccak_round_ctrl.sv
// tb/tb_keccak_round_ctrl.sv - directed self-checking bench for keccak_round_ctrl
module tb_keccak_round_ctrl;
    import keccak_pkg::*;

    localparam int PERM_LAT = 10465;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   cyc = 0;

    int nChecks = 0;
    int nFails  = 0;

    int dUnit    = -1;
    int dRound   = 0;
    int dIdx     = 0;
    int dExtra   = 0;
    bit spurious = 1'b0;

    int cdTh = 0, cdRho = 0, cdPi = 0, cdChi = 0, cdIota = 0;

    int nTh = 0, nRho = 0, nPi = 0, nChi = 0, nIota = 0;
    int nPermDone = 0, nLineMis = 0, nBack = 0;
    bit prevBusy = 1'b0;
    int prevRound = 0;

    keccak_round_ctrl_if bus ();

    keccak_round_ctrl dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic int extraFor(input int unit, input int r, input int idx);
        return (unit == dUnit && r == dRound && idx == dIdx) ? dExtra : 0;
    endfunction

    // Datapath stand-in: done arrives (1 + extra) negedges after the INIT strobe.
    always @(negedge clk) begin
        if (rst) begin
            cdTh = 0; cdRho = 0; cdPi = 0; cdChi = 0; cdIota = 0;
            bus.colparDone = 1'b0; bus.finishLane = 1'b0; bus.permDone = 1'b0;
            bus.revalDone = 1'b0; bus.addRCDone = 1'b0;
        end else begin
            if (bus.colparIJrster) begin
                cdTh = 1 + extraFor(0, int'(bus.roundIdx), int'(bus.sliceIdx)); bus.colparDone = 1'b0;
            end else if (cdTh > 0) begin
                cdTh = cdTh - 1; bus.colparDone = (cdTh == 0);
            end else bus.colparDone = 1'b0;

            if (bus.initRotate) begin
                cdRho = 1 + extraFor(1, int'(bus.roundIdx), int'(bus.laneIdx)); bus.finishLane = 1'b0;
            end else if (cdRho > 0) begin
                cdRho = cdRho - 1; bus.finishLane = (cdRho == 0);
            end else bus.finishLane = 1'b0;

            if (bus.IJen) begin
                cdPi = 1 + extraFor(2, int'(bus.roundIdx), int'(bus.sliceIdx)); bus.permDone = 1'b0;
            end else if (cdPi > 0) begin
                cdPi = cdPi - 1; bus.permDone = (cdPi == 0);
            end else bus.permDone = 1'b0;

            if (bus.initReval) begin
                cdChi = 1 + extraFor(3, int'(bus.roundIdx), int'(bus.sliceIdx)); bus.revalDone = 1'b0;
            end else if (cdChi > 0) begin
                cdChi = cdChi - 1; bus.revalDone = (cdChi == 0);
            end else bus.revalDone = 1'b0;

            if (bus.initARC) begin
                cdIota = 1 + extraFor(4, int'(bus.roundIdx), 0); bus.addRCDone = 1'b0;
            end else if (cdIota > 0) begin
                cdIota = cdIota - 1; bus.addRCDone = (cdIota == 0);
            end else bus.addRCDone = 1'b0;

            if (spurious && cdTh > 0) begin
                bus.revalDone = 1'b1;
                bus.addRCDone = 1'b1;
            end
        end
    end

    always @(negedge clk) begin
        if (bus.colparIJrster === 1'b1) nTh++;
        if (bus.initRotate === 1'b1) nRho++;
        if (bus.IJen === 1'b1) nPi++;
        if (bus.initReval === 1'b1) nChi++;
        if (bus.initARC === 1'b1) nIota++;
        if (bus.initLine !== bus.IJen) nLineMis++;
        if (bus.perm_done === 1'b1) nPermDone++;
        if (bus.busy === 1'b1 && prevBusy && int'(bus.roundIdx) < prevRound) nBack++;
        prevBusy  = (bus.busy === 1'b1);
        prevRound = int'(bus.roundIdx);
    end

    task automatic launch(output int c0);
        @(posedge clk);
        #1 bus.start = 1'b1;
        c0 = cyc;
        @(posedge clk);
        #1 bus.start = 1'b0;
    endtask

    task automatic waitPermDone(input int budget, output int at);
        at = -1;
        for (int k = 0; k < budget; k++) begin
            @(negedge clk);
            if (bus.perm_done === 1'b1) begin
                at = cyc;
                break;
            end
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(negedge clk);
        nChecks++;
        if ({bus.colparIJrster, bus.initRotate, bus.IJen, bus.initLine, bus.initReval, bus.initARC} !== 6'b0) begin
            nFails++; $display("FAIL reset_strobes: got %b expected 000000",
                {bus.colparIJrster, bus.initRotate, bus.IJen, bus.initLine, bus.initReval, bus.initARC});
        end
        nChecks++;
        if ({bus.sliceIdx, bus.laneIdx, bus.roundIdx} !== 16'h0) begin
            nFails++; $display("FAIL reset_indices: got %h expected 0000", {bus.sliceIdx, bus.laneIdx, bus.roundIdx});
        end
        nChecks++;
        if ({bus.busy, bus.perm_done, bus.err} !== 3'b000) begin
            nFails++; $display("FAIL reset_flags: got %b expected 000", {bus.busy, bus.perm_done, bus.err});
        end
        rst = 1'b0;
        repeat (3) @(negedge clk);
        nChecks++;
        if ({bus.busy, bus.colparIJrster} !== 2'b00) begin
            nFails++; $display("FAIL idle_after_reset: got %b expected 00", {bus.busy, bus.colparIJrster});
        end
    endtask

    task automatic test_ideal_perm();
        int c0, at, th0, rho0, pi0, chi0, iota0, p0, lm0;
        th0 = nTh; rho0 = nRho; pi0 = nPi; chi0 = nChi; iota0 = nIota; p0 = nPermDone; lm0 = nLineMis;
        launch(c0);
        waitPermDone(PERM_LAT + 500, at);
        nChecks++;
        if (at - c0 !== PERM_LAT) begin
            nFails++; $display("FAIL ideal_latency: got %0d expected %0d", at - c0, PERM_LAT);
        end
        @(negedge clk);
        nChecks++;
        if (bus.perm_done !== 1'b0) begin
            nFails++; $display("FAIL perm_done_width: got %b expected 0 one cycle later", bus.perm_done);
        end
        nChecks++;
        if (nTh - th0 !== NROUNDS * NSLICES) begin
            nFails++; $display("FAIL theta_strobes: got %0d expected %0d", nTh - th0, NROUNDS * NSLICES);
        end
        nChecks++;
        if (nRho - rho0 !== NROUNDS * NLANES) begin
            nFails++; $display("FAIL rho_strobes: got %0d expected %0d", nRho - rho0, NROUNDS * NLANES);
        end
        nChecks++;
        if (nPi - pi0 !== NROUNDS * NSLICES) begin
            nFails++; $display("FAIL pi_strobes: got %0d expected %0d", nPi - pi0, NROUNDS * NSLICES);
        end
        nChecks++;
        if (nChi - chi0 !== NROUNDS * NSLICES) begin
            nFails++; $display("FAIL chi_strobes: got %0d expected %0d", nChi - chi0, NROUNDS * NSLICES);
        end
        nChecks++;
        if (nIota - iota0 !== NROUNDS) begin
            nFails++; $display("FAIL iota_strobes: got %0d expected %0d", nIota - iota0, NROUNDS);
        end
        nChecks++;
        if (nPermDone - p0 !== 1) begin
            nFails++; $display("FAIL ideal_perm_done_count: got %0d expected 1", nPermDone - p0);
        end
        nChecks++;
        if (nLineMis - lm0 !== 0) begin
            nFails++; $display("FAIL initLine_vs_IJen: got %0d mismatching cycles expected 0", nLineMis - lm0);
        end
        nChecks++;
        if ({bus.busy, bus.roundIdx, bus.err} !== {1'b0, 5'd23, 1'b0}) begin
            nFails++; $display("FAIL post_perm_state: got busy=%b round=%0d err=%b expected busy=0 round=23 err=0",
                bus.busy, bus.roundIdx, bus.err);
        end
    endtask

    task automatic test_chi_delay();
        int c0, at, k, hold;
        dUnit = 3; dRound = 5; dIdx = 10; dExtra = 3;
        launch(c0);
        for (k = 0; k < 4000; k++) begin
            @(negedge clk);
            if (bus.initReval && bus.roundIdx == 5'd5 && bus.sliceIdx == 6'd10) break;
        end
        nChecks++;
        if (k >= 4000) begin
            nFails++; $display("FAIL chi_slice10_reached: not seen within 4000 cycles");
        end
        hold = 0;
        for (int j = 0; j < 4; j++) begin
            @(negedge clk);
            if (bus.sliceIdx == 6'd10 && !bus.initReval) hold++;
        end
        nChecks++;
        if (hold !== 4) begin
            nFails++; $display("FAIL chi_slice_hold: got %0d held cycles expected 4", hold);
        end
        @(negedge clk);
        nChecks++;
        if ({bus.initReval, bus.sliceIdx} !== {1'b1, 6'd11}) begin
            nFails++; $display("FAIL chi_resume: got initReval=%b slice=%0d expected 1 and 11", bus.initReval, bus.sliceIdx);
        end
        waitPermDone(PERM_LAT, at);
        nChecks++;
        if (at - c0 !== PERM_LAT + 3) begin
            nFails++; $display("FAIL chi_delay_latency: got %0d expected %0d", at - c0, PERM_LAT + 3);
        end
        nChecks++;
        if (bus.err !== 1'b0) begin
            nFails++; $display("FAIL chi_delay_err: got %b expected 0", bus.err);
        end
        dUnit = -1;
        repeat (2) @(negedge clk);
    endtask

    task automatic test_start_ignored();
        int c0, at, p0, b0, r;
        launch(c0);
        p0 = nPermDone; b0 = nBack;
        while (cyc < c0 + 100) @(posedge clk);
        #1 bus.start = 1'b1; r = int'(bus.roundIdx);
        @(posedge clk);
        #1 bus.start = 1'b0;
        nChecks++;
        if ({bus.busy, int'(bus.roundIdx)} !== {1'b1, r}) begin
            nFails++; $display("FAIL start_at_100: got busy=%b round=%0d expected busy=1 round=%0d", bus.busy, bus.roundIdx, r);
        end
        while (cyc < c0 + 500) @(posedge clk);
        #1 bus.start = 1'b1; r = int'(bus.roundIdx);
        @(posedge clk);
        #1 bus.start = 1'b0;
        nChecks++;
        if ({bus.busy, int'(bus.roundIdx)} !== {1'b1, r}) begin
            nFails++; $display("FAIL start_at_500: got busy=%b round=%0d expected busy=1 round=%0d", bus.busy, bus.roundIdx, r);
        end
        waitPermDone(PERM_LAT, at);
        nChecks++;
        if (at - c0 !== PERM_LAT) begin
            nFails++; $display("FAIL start_ignored_latency: got %0d expected %0d", at - c0, PERM_LAT);
        end
        repeat (3) @(negedge clk);
        nChecks++;
        if (nPermDone - p0 !== 1) begin
            nFails++; $display("FAIL start_ignored_done_count: got %0d expected 1", nPermDone - p0);
        end
        nChecks++;
        if (nBack - b0 !== 0) begin
            nFails++; $display("FAIL round_backstep: got %0d backward steps expected 0", nBack - b0);
        end
    endtask

    task automatic test_timeout();
        int c0, k, ci, ce, s0;
        dUnit = 1; dRound = 2; dIdx = 7; dExtra = 100000;
        launch(c0);
        for (k = 0; k < 2000; k++) begin
            @(negedge clk);
            if (bus.initRotate && bus.roundIdx == 5'd2 && bus.laneIdx == 5'd7) break;
        end
        ci = cyc;
        nChecks++;
        if (k >= 2000) begin
            nFails++; $display("FAIL rho_lane7_reached: not seen within 2000 cycles");
        end
        ce = -1;
        for (k = 0; k < 400; k++) begin
            @(negedge clk);
            if (bus.err === 1'b1) begin
                ce = cyc;
                break;
            end
        end
        nChecks++;
        if (ce - ci !== 256) begin
            nFails++; $display("FAIL timeout_cycle: err rose %0d cycles after rho init expected 256", ce - ci);
        end
        nChecks++;
        if ({bus.busy, bus.perm_done, bus.colparIJrster, bus.initRotate, bus.IJen, bus.initReval, bus.initARC} !== 7'b0) begin
            nFails++; $display("FAIL err_outputs: got busy=%b perm_done=%b strobes=%b expected all 0", bus.busy, bus.perm_done,
                {bus.colparIJrster, bus.initRotate, bus.IJen, bus.initReval, bus.initARC});
        end
        s0 = nTh + nRho + nPi + nChi + nIota;
        @(posedge clk);
        #1 bus.start = 1'b1;
        @(posedge clk);
        #1 bus.start = 1'b0;
        repeat (10) @(negedge clk);
        nChecks++;
        if ({bus.err, bus.busy} !== 2'b10 || (nTh + nRho + nPi + nChi + nIota) - s0 !== 0) begin
            nFails++; $display("FAIL err_sticky: got err=%b busy=%b strobes=%0d expected err=1 busy=0 strobes=0",
                bus.err, bus.busy, (nTh + nRho + nPi + nChi + nIota) - s0);
        end
        rst = 1'b1;
        @(negedge clk);
        nChecks++;
        if ({bus.err, bus.busy, bus.roundIdx, bus.laneIdx} !== 12'h0) begin
            nFails++; $display("FAIL err_cleared_by_rst: got err=%b busy=%b round=%0d lane=%0d expected all 0",
                bus.err, bus.busy, bus.roundIdx, bus.laneIdx);
        end
        rst = 1'b0;
        dUnit = -1;
        repeat (2) @(negedge clk);
    endtask

    task automatic test_timeout_boundary();
        int c0, k, ci, cn;
        dUnit = 1; dRound = 0; dIdx = 0; dExtra = 254;
        launch(c0);
        for (k = 0; k < 300; k++) begin
            @(negedge clk);
            if (bus.initRotate && bus.roundIdx == 5'd0 && bus.laneIdx == 5'd0) break;
        end
        ci = cyc;
        cn = -1;
        for (k = 0; k < 400; k++) begin
            @(negedge clk);
            if (bus.initRotate === 1'b1) begin
                cn = cyc;
                break;
            end
        end
        nChecks++;
        if (cn - ci !== 256) begin
            nFails++; $display("FAIL done_at_timeout_gap: got %0d cycles between rho inits expected 256", cn - ci);
        end
        nChecks++;
        if ({bus.err, bus.busy, bus.laneIdx} !== {1'b0, 1'b1, 5'd1}) begin
            nFails++; $display("FAIL done_at_timeout_state: got err=%b busy=%b lane=%0d expected err=0 busy=1 lane=1",
                bus.err, bus.busy, bus.laneIdx);
        end
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        dUnit = -1;
        repeat (2) @(negedge clk);
    endtask

    task automatic test_reset_mid_perm();
        int c0, at, k, p0;
        launch(c0);
        p0 = nPermDone;
        for (k = 0; k < 6000; k++) begin
            @(negedge clk);
            if (bus.IJen && bus.roundIdx == 5'd12) break;
        end
        nChecks++;
        if (k >= 6000) begin
            nFails++; $display("FAIL round12_pi_reached: not seen within 6000 cycles");
        end
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        nChecks++;
        if ({bus.colparIJrster, bus.initRotate, bus.IJen, bus.initLine, bus.initReval, bus.initARC,
             bus.sliceIdx, bus.laneIdx, bus.roundIdx, bus.busy, bus.perm_done, bus.err} !== 25'h0) begin
            nFails++; $display("FAIL mid_reset_outputs: got busy=%b slice=%0d lane=%0d round=%0d strobes=%b expected all 0",
                bus.busy, bus.sliceIdx, bus.laneIdx, bus.roundIdx,
                {bus.colparIJrster, bus.initRotate, bus.IJen, bus.initReval, bus.initARC});
        end
        rst = 1'b0;
        repeat (5) @(negedge clk);
        nChecks++;
        if (nPermDone - p0 !== 0 || bus.busy !== 1'b0) begin
            nFails++; $display("FAIL mid_reset_abort: got perm_done pulses=%0d busy=%b expected 0 and 0", nPermDone - p0, bus.busy);
        end
        launch(c0);
        waitPermDone(PERM_LAT + 500, at);
        nChecks++;
        if (at - c0 !== PERM_LAT) begin
            nFails++; $display("FAIL restart_latency: got %0d expected %0d", at - c0, PERM_LAT);
        end
    endtask

    task automatic test_spurious_done();
        int c0, at, k, hold, chi0, iota0;
        dUnit = 0; dRound = 0; dIdx = 3; dExtra = 2; spurious = 1'b1;
        chi0 = nChi; iota0 = nIota;
        launch(c0);
        for (k = 0; k < 100; k++) begin
            @(negedge clk);
            if (bus.colparIJrster && bus.roundIdx == 5'd0 && bus.sliceIdx == 6'd3) break;
        end
        nChecks++;
        if (k >= 100) begin
            nFails++; $display("FAIL theta_slice3_reached: not seen within 100 cycles");
        end
        hold = 0;
        for (int j = 0; j < 2; j++) begin
            @(negedge clk);
            if (bus.sliceIdx == 6'd3 && bus.revalDone && bus.addRCDone &&
                !(bus.colparIJrster || bus.initReval || bus.initARC)) hold++;
        end
        nChecks++;
        if (hold !== 2) begin
            nFails++; $display("FAIL spurious_hold: got %0d undisturbed cycles expected 2", hold);
        end
        @(negedge clk);
        @(negedge clk);
        nChecks++;
        if ({bus.colparIJrster, bus.sliceIdx} !== {1'b1, 6'd4}) begin
            nFails++; $display("FAIL spurious_resume: got init=%b slice=%0d expected 1 and 4", bus.colparIJrster, bus.sliceIdx);
        end
        waitPermDone(PERM_LAT, at);
        nChecks++;
        if (at - c0 !== PERM_LAT + 2) begin
            nFails++; $display("FAIL spurious_latency: got %0d expected %0d", at - c0, PERM_LAT + 2);
        end
        nChecks++;
        if (nChi - chi0 !== NROUNDS * NSLICES || nIota - iota0 !== NROUNDS || bus.err !== 1'b0) begin
            nFails++; $display("FAIL spurious_counts: got chi=%0d iota=%0d err=%b expected %0d %0d 0",
                nChi - chi0, nIota - iota0, bus.err, NROUNDS * NSLICES, NROUNDS);
        end
        spurious = 1'b0;
        dUnit = -1;
    endtask

    initial begin
        bus.start = 1'b0;
        test_reset();
        test_ideal_perm();
        test_chi_delay();
        test_start_ignored();
        test_timeout();
        test_timeout_boundary();
        test_reset_mid_perm();
        test_spurious_done();
        $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
        $finish;
    end

endmodule

// File: doc/keccak_round_ctrl.md
Name: keccak_round_ctrl

Overview:
Sequencer for the Keccak-f[1600] step datapath (theta/colpar, rho/rotate, pi/permutation, chi/reval, iota/addRC). It runs NROUNDS rounds. In each round it walks every step over its slices or lanes, pulses the step-init strobes, waits for each unit's done flag and presents the current slice, lane and round indices. It is the only block that drives the datapath's init and reset controls. A top-level `start`/`perm_done` handshake lets the absorb/squeeze logic launch and observe whole permutations.

Parameters:
NROUNDS, 24, rounds per permutation
NSLICES, 64, slices walked per round by theta, pi and chi
NLANES, 25, lanes walked per round by rho
TIMEOUT, 255, maximum RUN-state cycles allowed before a unit's done flag arrives

Ports:
clk  in  1  clock; all logic on rising edge
rst  in  1  synchronous, active-high reset
start  in  1  launch permutation; honoured only in IDLE
colparDone  in  1  theta unit finished current slice
finishLane  in  1  rho unit finished current lane
permDone  in  1  pi unit finished current slice
revalDone  in  1  chi unit finished current slice
addRCDone  in  1  iota unit finished
colparIJrster  out  1  one-cycle theta init strobe
initRotate  out  1  one-cycle rho init strobe
IJen  out  1  one-cycle pi init strobe (also drives initLine)
initLine  out  1  same as IJen
initReval  out  1  one-cycle chi init strobe
initARC  out  1  one-cycle iota init strobe
sliceIdx  out  6  current slice, 0..NSLICES-1
laneIdx  out  5  current lane, 0..NLANES-1
roundIdx  out  5  current round, 0..NROUNDS-1
busy  out  1  high in every state except IDLE and ERR
perm_done  out  1  one-cycle pulse when the permutation completes
err  out  1  sticky watchdog error

Behaviour:
- All outputs are registered.
- Reset: state=IDLE; all strobes=0; sliceIdx, laneIdx, roundIdx=0; busy=0; perm_done=0; err=0. Reset mid-permutation aborts immediately, with no perm_done.
- States: IDLE, TH_INIT, TH_RUN, RHO_INIT, RHO_RUN, PI_INIT, PI_RUN, CHI_INIT, CHI_RUN, IOTA_INIT, IOTA_RUN, FINISH, ERR.
- IDLE: on start=1, go to TH_INIT on the next edge with roundIdx=0, sliceIdx=0, laneIdx=0.
- X_INIT states: the matching strobe is high for exactly that one cycle; the watchdog clears; the next state is always X_RUN. Done inputs are ignored in INIT states.
- X_RUN: only the active unit's done flag is sampled; all other done flags are ignored.
- On done in TH_RUN, PI_RUN or CHI_RUN:
  - if sliceIdx<NSLICES-1: sliceIdx+1, return to the same INIT;
  - else: sliceIdx=0, advance to the next step's INIT.
- On done in RHO_RUN:
  - if laneIdx<NLANES-1: laneIdx+1, return to RHO_INIT;
  - else: laneIdx=0, go to PI_INIT.
- Step order: TH → RHO → PI → CHI → IOTA.
- On addRCDone in IOTA_RUN:
  - if roundIdx<NROUNDS-1: roundIdx+1, go to TH_INIT;
  - else: go to FINISH.
- FINISH: perm_done=1 for exactly one cycle, then IDLE. roundIdx keeps NROUNDS-1 until the next start.
- start while busy is ignored and has no side effect.
- Watchdog: an 8-bit counter increments in every RUN cycle and saturates.
  - If it reaches TIMEOUT with no done flag, the next state is ERR with err=1.
  - A done flag in the same cycle that TIMEOUT is reached wins, and no error is raised.
  - ERR: all strobes 0, busy=0. Exit only via rst; start is ignored.
- Ideal latency, with each done arriving in the first RUN cycle:
  - theta 128, rho 50, pi 128, chi 128, iota 2 = 436 cycles/round;
  - start to perm_done = 1 + 24×436 = 10465 cycles.

Decomposition:
- Package keccak_pkg holds:
  - state enum (13 states);
  - constants NROUNDS, NSLICES, NLANES;
  - index widths SLICE_W=6, LANE_W=5, ROUND_W=5.
- One sub-module, keccak_wdog: saturating run-cycle counter with clear, enable and a timeout compare. Inputs clk, rst, clr, en; output expired.

Test Plan:
- Reset, then start with an ideal responder (each done asserted in the first RUN cycle) → perm_done pulses exactly 10465 cycles after start. Over that run: 24×64 colparIJrster pulses, 24×25 initRotate pulses, 24×64 IJen pulses, 24×64 initReval pulses, 24 initARC pulses.
- Responder delays chi done by 3 extra cycles on slice 10, round 5 → sliceIdx holds 10 through the wait; total latency grows by exactly 3; no err.
- Assert start at cycle 100 and cycle 500 during a permutation → ignored; a single perm_done at 10465 cycles after the first start; roundIdx never resets mid-run.
- Withhold finishLane in round 2, lane 7 → after 255 RUN cycles, err=1 and busy=0; state stays ERR despite a subsequent start; rst returns err=0 and state IDLE.
- Assert rst during round 12 in PI_RUN → next cycle all outputs are at reset values; no perm_done. A fresh start then completes normally in 10465 cycles.
- Pulse spurious revalDone and addRCDone while in TH_RUN → no state or index change; the sequence continues on colparDone only.
